// File: rtl/map_scan_pkg.sv
// Shared types, default geometry and the one-hot to binary helper
// for the map scan scheduler.
package map_scan_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } ScanState_t;

  localparam int DEF_DATA_X_W = 7;
  localparam int DEF_DATA_Y_W = 5;
  localparam int ONEHOT_MAX_W = 64;

  // Only the low `width` bits take part; an all-zero input encodes to 0.
  function automatic logic [31:0] Onehot2Bin(input logic [ONEHOT_MAX_W-1:0] onehot,
                                             input int width);
    Onehot2Bin = '0;
    for (int i = 0; i < ONEHOT_MAX_W; i++) begin
      if (i < width && onehot[i]) Onehot2Bin = Onehot2Bin | 32'(i);
    end
  endfunction

endpackage

// File: rtl/find_first_set_2d.sv
// FindFirstSet2D: locates the first set bit of a 2D bitmap, lowest row first,
// then LSB first within that row; results are one-hot per dimension.
module FindFirstSet2D #(
  parameter int DATA_X_W = 7,
  parameter int DATA_Y_W = 5
) (
  input  logic [DATA_X_W-1:0] data [DATA_Y_W-1:0],
  output logic [DATA_X_W-1:0] first_x,
  output logic [DATA_Y_W-1:0] first_y,
  output logic                any_set
);

  logic found;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    first_x = '0;
    first_y = '0;
    found   = 1'b0;
    for (int r = 0; r < DATA_Y_W; r++) begin
      if (!found && (|data[r])) begin
        first_y[r] = 1'b1;
        first_x    = data[r] & (~data[r] + DATA_X_W'(1));
        found      = 1'b1;
      end
    end
    any_set = found;
  end

endmodule

// File: rtl/map_scan_onehot_encoder.sv
// onehot_encoder: binary index of the single set bit of a one-hot vector.
module onehot_encoder
  import map_scan_pkg::*;
#(
  parameter int IN_W  = 7,
  parameter int OUT_W = 3
) (
  input  logic [IN_W-1:0]  onehot,
  output logic [OUT_W-1:0] bin
);

  assign bin = OUT_W'(Onehot2Bin(ONEHOT_MAX_W'(onehot), IN_W));

endmodule

// File: rtl/map_scan_scheduler.sv
// map_scan_scheduler: issues the coordinates of every set bit of a loaded
// bitmap in raster order, one per handshake, clearing each bit once issued.
module map_scan_scheduler
  import map_scan_pkg::*;
#(
  parameter  int DATA_X_W = DEF_DATA_X_W,
  parameter  int DATA_Y_W = DEF_DATA_Y_W,
  localparam int IDX_X_W  = (DATA_X_W > 1) ? $clog2(DATA_X_W) : 1,
  localparam int IDX_Y_W  = (DATA_Y_W > 1) ? $clog2(DATA_Y_W) : 1,
  localparam int CNT_W    = $clog2(DATA_X_W * DATA_Y_W + 1)
) (
  input  logic                Clk,
  input  logic                RstN,
  input  logic                MapValid,
  output logic                MapReady,
  input  logic [DATA_X_W-1:0] MapIn [DATA_Y_W-1:0],
  input  logic                Abort,
  output logic                CoordValid,
  input  logic                CoordReady,
  output logic [DATA_X_W-1:0] CoordX,
  output logic [DATA_Y_W-1:0] CoordY,
  output logic [IDX_X_W-1:0]  CoordXIdx,
  output logic [IDX_Y_W-1:0]  CoordYIdx,
  output logic                CoordLast,
  output logic                ScanDone,
  output logic [CNT_W-1:0]    IssuedCnt
);

  ScanState_t          state, state_nxt;
  logic [DATA_X_W-1:0] work_map [DATA_Y_W-1:0];
  logic [DATA_X_W-1:0] work_map_nxt [DATA_Y_W-1:0];
  logic [DATA_X_W-1:0] rest_map [DATA_Y_W-1:0];
  logic [CNT_W-1:0]    issued_cnt, issued_cnt_nxt;
  logic                scan_done, scan_done_nxt;
  logic [DATA_X_W-1:0] first_x;
  logic [DATA_Y_W-1:0] first_y;
  logic [IDX_X_W-1:0]  x_idx;
  logic [IDX_Y_W-1:0]  y_idx;
  logic                map_any, rest_any, map_in_any, handshake;

  FindFirstSet2D #(.DATA_X_W(DATA_X_W), .DATA_Y_W(DATA_Y_W)) FirstSet (
    .data    (work_map),
    .first_x (first_x),
    .first_y (first_y),
    .any_set (map_any)
  );

  onehot_encoder #(.IN_W(DATA_X_W), .OUT_W(IDX_X_W)) x_encoder (.onehot(first_x), .bin(x_idx));
  onehot_encoder #(.IN_W(DATA_Y_W), .OUT_W(IDX_Y_W)) y_encoder (.onehot(first_y), .bin(y_idx));

  // Working map with the current first bit removed; empty means it is the last one.
  always_comb begin
    rest_any   = 1'b0;
    map_in_any = 1'b0;
    for (int r = 0; r < DATA_Y_W; r++) begin
      rest_map[r] = work_map[r] & ~(first_y[r] ? first_x : '0);
      rest_any    = rest_any | (|rest_map[r]);
      map_in_any  = map_in_any | (|MapIn[r]);
    end
  end

  assign MapReady   = (state == IDLE);
  assign CoordValid = (state == SCAN) && map_any;
  assign CoordLast  = CoordValid && !rest_any;
  assign CoordX     = CoordValid ? first_x : '0;
  assign CoordY     = CoordValid ? first_y : '0;
  assign CoordXIdx  = CoordValid ? x_idx : '0;
  assign CoordYIdx  = CoordValid ? y_idx : '0;
  assign ScanDone   = scan_done;
  assign IssuedCnt  = issued_cnt;
  assign handshake  = CoordValid && CoordReady;

  always_comb begin
    state_nxt      = state;
    work_map_nxt   = work_map;
    issued_cnt_nxt = issued_cnt;
    scan_done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (MapValid) begin
          work_map_nxt   = MapIn;
          issued_cnt_nxt = '0;
          if (map_in_any) state_nxt = SCAN;
          else            scan_done_nxt = 1'b1;
        end
      end
      SCAN: begin
        if (handshake) begin
          work_map_nxt   = rest_map;
          issued_cnt_nxt = issued_cnt + CNT_W'(1);
        end
        // Abort wins over the handshake for state, but the handshake still counts.
        if (Abort || !map_any || (handshake && CoordLast)) begin
          work_map_nxt  = '{default: '0};
          state_nxt     = IDLE;
          scan_done_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments keep every register sampling pre-edge values.
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      state      <= IDLE;
      work_map   <= '{default: '0};
      issued_cnt <= '0;
      scan_done  <= 1'b0;
    end else begin
      state      <= state_nxt;
      work_map   <= work_map_nxt;
      issued_cnt <= issued_cnt_nxt;
      scan_done  <= scan_done_nxt;
    end
  end

endmodule

// File: tb/tb_map_scan_scheduler.sv
// Directed bench for map_scan_scheduler: per-cycle vector table plus
// hand-written full-map and asynchronous-reset sequences.
module tb_map_scan_scheduler;

  logic       Clk;
  logic       RstN;
  logic       MapValid;
  logic       MapReady;
  logic [6:0] map_in [4:0];
  logic       Abort;
  logic       CoordValid;
  logic       CoordReady;
  logic [6:0] CoordX;
  logic [4:0] CoordY;
  logic [2:0] CoordXIdx;
  logic [2:0] CoordYIdx;
  logic       CoordLast;
  logic       ScanDone;
  logic [5:0] IssuedCnt;

  int n_checks = 0;
  int n_pass   = 0;

  map_scan_scheduler dut (
    .Clk        (Clk),
    .RstN       (RstN),
    .MapValid   (MapValid),
    .MapReady   (MapReady),
    .MapIn      (map_in),
    .Abort      (Abort),
    .CoordValid (CoordValid),
    .CoordReady (CoordReady),
    .CoordX     (CoordX),
    .CoordY     (CoordY),
    .CoordXIdx  (CoordXIdx),
    .CoordYIdx  (CoordYIdx),
    .CoordLast  (CoordLast),
    .ScanDone   (ScanDone),
    .IssuedCnt  (IssuedCnt)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  typedef struct {
    logic            load;
    logic [4:0][6:0] map;
    logic            ready;
    logic            abort;
    logic            exp_mr;
    logic            exp_v;
    int              exp_y;
    int              exp_x;
    logic            exp_last;
    logic            exp_done;
    int              exp_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [4:0][6:0] mk(input logic [6:0] r0, r1, r2, r3, r4);
    mk = {r4, r3, r2, r1, r0};
  endfunction

  task automatic add(input logic load, input logic [4:0][6:0] map, input logic ready,
                     input logic abort, input logic mr, input logic v, input int y,
                     input int x, input logic last, input logic done, input int cnt);
    vec_t e;
    e.load = load; e.map = map; e.ready = ready; e.abort = abort;
    e.exp_mr = mr; e.exp_v = v; e.exp_y = y; e.exp_x = x;
    e.exp_last = last; e.exp_done = done; e.exp_cnt = cnt;
    vecs.push_back(e);
  endtask

  // {MapReady, CoordValid, CoordY, CoordX, CoordYIdx, CoordXIdx, CoordLast, ScanDone, IssuedCnt}
  function automatic logic [27:0] expect_word(input logic mr, input logic v, input int y,
                                              input int x, input logic last, input logic done,
                                              input int cnt);
    logic [4:0] oy;
    logic [6:0] ox;
    oy = v ? (5'd1 << y) : 5'd0;
    ox = v ? (7'd1 << x) : 7'd0;
    expect_word = {mr, v, oy, ox, v ? 3'(y) : 3'd0, v ? 3'(x) : 3'd0, last, done, 6'(cnt)};
  endfunction

  function automatic logic [27:0] actual_word();
    actual_word = {MapReady, CoordValid, CoordY, CoordX, CoordYIdx, CoordXIdx,
                   CoordLast, ScanDone, IssuedCnt};
  endfunction

  task automatic check(input string name, input logic [27:0] act, input logic [27:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input logic load, input logic [4:0][6:0] map, input logic ready,
                       input logic abort);
    MapValid   = load;
    CoordReady = ready;
    Abort      = abort;
    for (int r = 0; r < 5; r++) map_in[r] = map[r];
  endtask

  // Inputs change 1 time unit after the edge; outputs are sampled 1 unit later.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  logic [4:0][6:0] m1, m5, m6, m7, mfull;

  initial begin
    RstN = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);
    m1    = mk(7'h04, 7'h08, 7'h02, 7'h0C, 7'h00);
    m5    = mk(7'h7F, 7'h00, 7'h00, 7'h00, 7'h00);
    m6    = mk(7'h00, 7'h00, 7'h10, 7'h00, 7'h00);
    m7    = mk(7'h00, 7'h00, 7'h00, 7'h00, 7'h40);
    mfull = mk(7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F);

    // Basic scan; first vector also covers the reset state.
    add(1, m1, 1, 0,  1, 0, 0, 0, 0, 0, 0);
    add(0, '0, 1, 0,  0, 1, 0, 2, 0, 0, 0);
    add(0, '0, 1, 0,  0, 1, 1, 3, 0, 0, 1);
    add(0, '0, 1, 0,  0, 1, 2, 1, 0, 0, 2);
    add(0, '0, 1, 0,  0, 1, 3, 2, 0, 0, 3);
    add(0, '0, 1, 0,  0, 1, 3, 3, 1, 0, 4);
    add(0, '0, 1, 0,  1, 0, 0, 0, 0, 1, 5);
    add(0, '0, 1, 0,  1, 0, 0, 0, 0, 0, 5);
    // Backpressure, ready pattern 1,0,0,1 repeating.
    add(1, m1, 1, 0,  1, 0, 0, 0, 0, 0, 5);
    add(0, '0, 1, 0,  0, 1, 0, 2, 0, 0, 0);
    add(0, '0, 0, 0,  0, 1, 1, 3, 0, 0, 1);
    add(0, '0, 0, 0,  0, 1, 1, 3, 0, 0, 1);
    add(0, '0, 1, 0,  0, 1, 1, 3, 0, 0, 1);
    add(0, '0, 1, 0,  0, 1, 2, 1, 0, 0, 2);
    add(0, '0, 0, 0,  0, 1, 3, 2, 0, 0, 3);
    add(0, '0, 0, 0,  0, 1, 3, 2, 0, 0, 3);
    add(0, '0, 1, 0,  0, 1, 3, 2, 0, 0, 3);
    add(0, '0, 1, 0,  0, 1, 3, 3, 1, 0, 4);
    add(0, '0, 0, 0,  1, 0, 0, 0, 0, 1, 5);
    // Empty map.
    add(1, '0, 1, 0,  1, 0, 0, 0, 0, 0, 5);
    add(0, '0, 1, 0,  1, 0, 0, 0, 0, 1, 0);
    add(0, '0, 1, 0,  1, 0, 0, 0, 0, 0, 0);
    // Abort together with the third handshake, then reload next cycle.
    add(1, m5, 1, 0,  1, 0, 0, 0, 0, 0, 0);
    add(0, '0, 1, 0,  0, 1, 0, 0, 0, 0, 0);
    add(0, '0, 1, 0,  0, 1, 0, 1, 0, 0, 1);
    add(0, '0, 1, 1,  0, 1, 0, 2, 0, 0, 2);
    add(1, m6, 0, 0,  1, 0, 0, 0, 0, 1, 3);
    add(0, '0, 0, 0,  0, 1, 2, 4, 1, 0, 0);
    add(0, '0, 1, 0,  0, 1, 2, 4, 1, 0, 0);
    // Abort in IDLE is ignored; the load still happens.
    add(1, m7, 0, 1,  1, 0, 0, 0, 0, 1, 1);
    add(0, '0, 1, 0,  0, 1, 4, 6, 1, 0, 0);
    add(0, '0, 0, 0,  1, 0, 0, 0, 0, 1, 1);
    add(0, '0, 0, 0,  1, 0, 0, 0, 0, 0, 1);

    #12 RstN = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      step();
      drive(vecs[i].load, vecs[i].map, vecs[i].ready, vecs[i].abort);
      #1;
      check($sformatf("vec%0d", i), actual_word(),
            expect_word(vecs[i].exp_mr, vecs[i].exp_v, vecs[i].exp_y, vecs[i].exp_x,
                        vecs[i].exp_last, vecs[i].exp_done, vecs[i].exp_cnt));
    end

    // Full map: 35 coordinates in raster order, last only on (4,6).
    step();
    drive(1'b1, mfull, 1'b1, 1'b0);
    #1;
    check("full_load", actual_word(), expect_word(1, 0, 0, 0, 0, 0, 1));
    for (int y = 0; y < 5; y++) begin
      for (int x = 0; x < 7; x++) begin
        step();
        drive(1'b0, '0, 1'b1, 1'b0);
        #1;
        check($sformatf("full_y%0d_x%0d", y, x), actual_word(),
              expect_word(0, 1, y, x, (y == 4 && x == 6), 0, y * 7 + x));
      end
    end
    step();
    drive(1'b0, '0, 1'b0, 1'b0);
    #1;
    check("full_done", actual_word(), expect_word(1, 0, 0, 0, 0, 1, 35));

    // Asynchronous reset between edges in the middle of a scan.
    step();
    drive(1'b1, m5, 1'b1, 1'b0);
    #1;
    step();
    drive(1'b0, '0, 1'b1, 1'b0);
    #1;
    check("rst_pre_first", actual_word(), expect_word(0, 1, 0, 0, 0, 0, 0));
    step();
    #1;
    check("rst_pre_second", actual_word(), expect_word(0, 1, 0, 1, 0, 0, 1));
    #1 RstN = 1'b0;
    #1;
    check("rst_immediate", actual_word(), expect_word(1, 0, 0, 0, 0, 0, 0));
    step();
    #1;
    check("rst_held", actual_word(), expect_word(1, 0, 0, 0, 0, 0, 0));
    RstN = 1'b1;
    step();
    #1;
    check("rst_no_done", actual_word(), expect_word(1, 0, 0, 0, 0, 0, 0));
    step();
    #1;
    check("rst_still_idle", actual_word(), expect_word(1, 0, 0, 0, 0, 0, 0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
